// File: rtl/decode_buffer_if.sv
// Shared payload types and the valid/ready handshake interface for the fetch-to-decode path.
package decode_buffer_pkg;

  typedef struct packed {
    logic [1:0]       mask;
    logic [1:0][31:0] pc;
    logic [1:0][31:0] insts;
  } f_d_pkg_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } decode_entry_t;

endpackage

interface handshake_if;
  import decode_buffer_pkg::*;

  logic     valid;
  logic     ready;
  f_d_pkg_t data;

  modport sender   (output valid, output data, input ready);
  modport receiver (input valid, input data, output ready);
endinterface

// File: rtl/decode_buffer.sv
// Compacting 2-wide instruction queue between fetch and decode (the registered D-stage point).
// Macro DECODE_BUFFER_BYPASS_EN adds a zero-latency path from fetch to decode while empty.
module decode_buffer
  import decode_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  handshake_if.receiver         receiver,
  handshake_if.sender           sender,
  output logic [$clog2(DEPTH):0] occupancy_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]  head_q, head_d;
  logic [AW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  decode_entry_t  mem_q [DEPTH];
  decode_entry_t  mem_d [DEPTH];

  logic [AW-1:0]  head_p1;
  logic [AW-1:0]  tail_p1;
  decode_entry_t  in_e0, in_e1;
  logic [1:0]     in_cnt;
  f_d_pkg_t       buf_pkt;
  f_d_pkg_t       out_pkt;
  logic           out_valid;
  logic           rx_ready;
  logic           push_fire;
  logic           byp_take;
  logic [1:0]     push_cnt;
  logic           pop_fire;
  logic [1:0]     pop_cnt;

  assign head_p1 = head_q + AW'(1);
  assign tail_p1 = tail_q + AW'(1);

  // Ready looks only at the registered count so it never waits on the decoder.
  assign rx_ready       = (count_q <= CW'(DEPTH - 2));
  assign receiver.ready = rx_ready;
  assign occupancy_o    = count_q;

  // Compact the sparse fetch mask into up to two dense entries, oldest first.
  always_comb begin
    in_e0  = '0;
    in_e1  = '0;
    in_cnt = 2'd0;
    unique case (receiver.data.mask)
      2'b01: begin
        in_e0.pc   = receiver.data.pc[0];
        in_e0.inst = receiver.data.insts[0];
        in_cnt     = 2'd1;
      end
      2'b10: begin
        in_e0.pc   = receiver.data.pc[1];
        in_e0.inst = receiver.data.insts[1];
        in_cnt     = 2'd1;
      end
      2'b11: begin
        in_e0.pc   = receiver.data.pc[0];
        in_e0.inst = receiver.data.insts[0];
        in_e1.pc   = receiver.data.pc[1];
        in_e1.inst = receiver.data.insts[1];
        in_cnt     = 2'd2;
      end
      default: begin
        in_cnt = 2'd0;
      end
    endcase
  end

  // Dense packet from storage; slots beyond the current count read as zero.
  always_comb begin
    buf_pkt = '0;
    if (count_q != '0) begin
      buf_pkt.mask[0]  = 1'b1;
      buf_pkt.pc[0]    = mem_q[head_q].pc;
      buf_pkt.insts[0] = mem_q[head_q].inst;
    end
    if (count_q >= CW'(2)) begin
      buf_pkt.mask[1]  = 1'b1;
      buf_pkt.pc[1]    = mem_q[head_p1].pc;
      buf_pkt.insts[1] = mem_q[head_p1].inst;
    end
  end

`ifdef DECODE_BUFFER_BYPASS_EN
  logic     byp_sel;
  logic     byp_valid;
  f_d_pkg_t byp_pkt;

  assign byp_sel   = (count_q == '0) & ~flush_i;
  assign byp_valid = receiver.valid & (in_cnt != 2'd0);
  assign byp_take  = byp_sel & byp_valid & sender.ready;

  // Bypass packet is gated by valid so an idle fetch port still presents zeros.
  always_comb begin
    byp_pkt = '0;
    if (receiver.valid) begin
      byp_pkt.mask     = (in_cnt == 2'd2) ? 2'b11 : ((in_cnt == 2'd1) ? 2'b01 : 2'b00);
      byp_pkt.pc[0]    = in_e0.pc;
      byp_pkt.insts[0] = in_e0.inst;
      byp_pkt.pc[1]    = in_e1.pc;
      byp_pkt.insts[1] = in_e1.inst;
    end
  end

  always_comb begin
    out_valid = (count_q != '0) & ~flush_i;
    out_pkt   = buf_pkt;
    if (byp_sel) begin
      out_valid = byp_valid;
      out_pkt   = byp_pkt;
    end
  end
`else
  assign byp_take  = 1'b0;
  assign out_valid = (count_q != '0) & ~flush_i;
  assign out_pkt   = buf_pkt;
`endif

  assign sender.valid = out_valid;
  assign sender.data  = out_pkt;

  // A bypassed packet is consumed directly and never enters storage.
  assign push_fire = receiver.valid & rx_ready & ~flush_i;
  assign push_cnt  = (push_fire & ~byp_take) ? in_cnt : 2'd0;

  assign pop_fire = out_valid & sender.ready & (count_q != '0);
  assign pop_cnt  = pop_fire ? ((count_q >= CW'(2)) ? 2'd2 : 2'd1) : 2'd0;

  // Flush wins over any same-cycle push or pop.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_cnt != 2'd0) begin
        mem_d[tail_q] = in_e0;
      end
      if (push_cnt == 2'd2) begin
        mem_d[tail_p1] = in_e1;
      end
      tail_d  = tail_q + AW'(push_cnt);
      head_d  = head_q + AW'(pop_cnt);
      count_d = count_q + CW'(push_cnt) - CW'(pop_cnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry contents need no reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  a_mask_dense : assert property (@(posedge clk) disable iff (rst)
    sender.valid |-> (sender.data.mask != 2'b10));

  a_count_bound : assert property (@(posedge clk) disable iff (rst)
    count_q <= CW'(DEPTH));

endmodule

// File: doc/decode_buffer.md
# decode_buffer

Instruction buffer between fetch and the decoder. It accepts 2-wide fetch packets whose per-slot valid mask may be sparse, and compacts the valid instructions into a circular queue. It presents the oldest one or two instructions to the decoder as a dense packet, and it is the only registered point of the D stage. A flush empties the buffer in one cycle.

## Interface

Parameters:
- `DEPTH`, default 8. Number of single-instruction entries. Power of two, at least 4.

Ports:
- `clk`: input, 1 bit. Clock.
- `rst`: input, 1 bit. One clock; reset is asynchronous and active-high.
- `flush_i`: input, 1 bit. Synchronous flush (redirect or exception).
- `receiver`: `handshake_if.receiver`, `f_d_pkg_t`. Fetch packet: `mask[1:0]`, `pc[1:0][31:0]`, `insts[1:0][31:0]`.
- `sender`: `handshake_if.sender`, `f_d_pkg_t`. Packet to the decoder, same type. Mask is always 2'b00, 2'b01 or 2'b11.
- `occupancy_o`: output, $clog2(DEPTH)+1 bits. Current entry count.

## Operation

- Each entry stores {pc[31:0], inst[31:0]}.
- Storage uses head and tail pointers of $clog2(DEPTH) bits with natural wrap, plus a count register of $clog2(DEPTH)+1 bits.

Push, on `receiver.valid & receiver.ready`:
- Mask 2'b11: slot0 is written at the tail and slot1 at tail+1. Tail advances by 2.
- Mask 2'b01: slot0 is written at the tail. Tail advances by 1.
- Mask 2'b10: slot1 is written at the tail. Tail advances by 1.
- Mask 2'b00: the packet is accepted and nothing is written.
- `receiver.ready = (DEPTH - count) >= 2`. This uses the current count only. It never depends on `sender.ready` or `flush_i`.

Output:
- `sender.valid = (count != 0) & ~flush_i`.
- Slot0 carries the entry at head. Slot1 carries the entry at head+1.
- Mask is 2'b11 when count is at least 2, 2'b01 when count is 1, and 2'b00 when count is 0.
- Empty slots drive pc and inst as zero.

Pop, on `sender.valid & sender.ready`:
- Head advances by popcount(mask). The decoder consumes the whole packet or nothing.

Same-cycle push and pop:
- `count_next = count + pushed - popped`.
- Entries written this cycle never alias the entries read this cycle, because `receiver.ready` guarantees 2 free entries.

Flush (highest priority):
- Head, tail and count go to 0.
- Any push or pop in the same cycle is discarded.
- `sender.valid` is 0 in that cycle. `receiver.ready` still follows count, and an accepted packet is dropped.

Reset values:
- Head, tail and count are 0. Entry contents are don't-care.
- After reset, `sender.valid` = 0, `sender.data` = all zero, `receiver.ready` = 1 and `occupancy_o` = 0.

## Timing

- Push-to-visible latency is 1 cycle: an instruction accepted at edge N is presented after edge N. The exception is the bypass path (see Configuration).
- Throughput is a sustained 2 instructions per cycle in and out when the decoder is always ready and count stays between 2 and DEPTH-2.
- Full: when count is DEPTH-1 or DEPTH, `receiver.ready` = 0 even if a pop happens in the same cycle. This is accepted one-cycle bubble behaviour.
- Empty: `sender.valid` = 0. A push into an empty buffer is visible on the next cycle.
- `occupancy_o` is registered and equals count.

## Configuration

`DECODE_BUFFER_BYPASS_EN`. Defined:
- When count is 0 and `flush_i` is 0, the input packet is compacted and driven combinationally to `sender`, with `sender.valid = receiver.valid & (mask != 0)`.
- If `sender.ready` is 1, the instructions are not stored.
- If the decoder is not ready, they are stored normally.
- Compaction maps mask 2'b10 to output slot0 with mask 2'b01.
- Latency is 0 cycles when the buffer is empty.

Not defined:
- No combinational path from `receiver` to `sender`.
- Minimum latency is 1 cycle.

## Test plan

- Reset, then push {mask 11, pc 0x1c000000/0x1c000004} with the decoder ready. Next cycle the output is mask 11 with the same pcs. Count goes 2 then 0.
- Push mask 10 (pc1 0x1c000004), then mask 01 (pc0 0x1c000008), with the decoder stalled. The output is mask 11, slot0 pc 0x1c000004, slot1 pc 0x1c000008, and count is 2.
- With DEPTH 8, push four mask-11 packets while stalled. Count reaches 8 and `receiver.ready` = 0 from count 7 onward. A fifth valid packet is held by the source and is not lost.
- Stream 20 mask-11 packets with the decoder always ready. The pc sequence out equals the sequence in. Count wraps the pointers at least twice with no bubble after fill.
- With count 5, assert `flush_i` together with `receiver.valid`. Next cycle count = 0 and `sender.valid` = 0, and the flush-cycle packet is absent.
- Count 1 with the decoder ready: the output mask is 01 and the pop is 1. With the bypass defined and the buffer empty, a pushed mask-01 packet appears on `sender` in the same cycle.
